multi_byte_decoder: RTL and testbench

- Parametrised successor to the fixed three-state opcode/immediate decoder.
- Consumes a byte stream from the fetch unit over a valid/ready handshake.
- Classifies each 6502 opcode into an addressing mode and instruction length of 1 to 3 bytes, and collects 0 to 2 operand bytes little-endian.
- Emits one decoded micro-op per instruction to the execute stage over a second valid/ready handshake, with flush support for branch redirects.

---
 rtl/multi_byte_decoder_pkg.sv | 19 +
 rtl/multi_byte_decoder_opcode_mode_lut.sv | 75 +++++++
 rtl/multi_byte_decoder.sv | 145 ++++++++++++++
 tb/tb_multi_byte_decoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_byte_decoder_pkg.sv
// Shared types for the 6502 multi-byte decoder: addressing modes, FSM states,
// and the mode-to-instruction-length rule.
package decoder_pkg;

    typedef enum logic [3:0] {
        IMPL, ACC, IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, IND, IND_X, IND_Y, REL, ERR
    } addr_mode_t;

    typedef enum logic [1:0] {S_OP, S_LO, S_HI, S_ISSUE} dec_state_t;

    function automatic logic [1:0] mode_len(input addr_mode_t m);
        case (m)
            IMPL, ACC, ERR:         mode_len = 2'd1;
            ABS, ABS_X, ABS_Y, IND: mode_len = 2'd3;
            default:                mode_len = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/multi_byte_decoder_opcode_mode_lut.sv
// Combinational 6502 opcode classifier: documented opcodes only, everything
// else maps to ERR (length 1, illegal).
module opcode_mode_lut
    import decoder_pkg::*;
(
    input  logic [7:0] opcode,
    output addr_mode_t mode,
    output logic [1:0] len,
    output logic       illegal
);

    logic [1:0] cc;
    logic [2:0] bbb;

    assign cc  = opcode[1:0];
    assign bbb = opcode[4:2];

    always_comb begin
        mode = ERR;
        case (cc)
            2'b01: begin
                case (bbb)
                    3'b000: mode = IND_X;
                    3'b001: mode = ZPG;
                    3'b010: mode = IMM;
                    3'b011: mode = ABS;
                    3'b100: mode = IND_Y;
                    3'b101: mode = ZPG_X;
                    3'b110: mode = ABS_Y;
                    3'b111: mode = ABS_X;
                    default: mode = ERR;
                endcase
                if (opcode == 8'h89) mode = ERR;
            end
            2'b00, 2'b10: begin
                case (bbb)
                    3'b000: begin
                        if (opcode inside {8'h00, 8'h40, 8'h60})              mode = IMPL;
                        else if (opcode == 8'h20)                             mode = ABS;
                        else if (opcode inside {8'hA0, 8'hA2, 8'hC0, 8'hE0})  mode = IMM;
                    end
                    3'b001: if (cc == 2'b10 || opcode inside {8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4})
                                mode = ZPG;
                    3'b010: begin
                        if (cc == 2'b00)                                      mode = IMPL;
                        else if (opcode inside {8'h0A, 8'h2A, 8'h4A, 8'h6A})  mode = ACC;
                        else if (opcode inside {8'h8A, 8'hAA, 8'hCA, 8'hEA})  mode = IMPL;
                    end
                    3'b011: begin
                        if (opcode == 8'h6C) mode = IND;
                        else if (cc == 2'b10 || opcode inside {8'h2C, 8'h4C, 8'h8C, 8'hAC, 8'hCC, 8'hEC})
                            mode = ABS;
                    end
                    3'b100: if (cc == 2'b00) mode = REL;
                    // STX/LDX index with Y, so their zero-page forms are ZPG_Y
                    3'b101: begin
                        if (opcode inside {8'h96, 8'hB6}) mode = ZPG_Y;
                        else if (cc == 2'b10 || opcode inside {8'h94, 8'hB4}) mode = ZPG_X;
                    end
                    3'b110: if (cc == 2'b00 || opcode inside {8'h9A, 8'hBA}) mode = IMPL;
                    3'b111: begin
                        if (opcode == 8'hBE) mode = ABS_Y;
                        else if ((cc == 2'b10 && opcode != 8'h9E) || opcode == 8'hBC) mode = ABS_X;
                    end
                    default: mode = ERR;
                endcase
            end
            default: mode = ERR;
        endcase
    end

    assign len     = mode_len(mode);
    assign illegal = (mode == ERR);

endmodule

// File: rtl/multi_byte_decoder.sv
// Byte-stream 6502 instruction decoder: gathers opcode + operands and issues one
// micro-op per instruction. Define MULTI_BYTE_DECODER_STATS_EN for issue counters.
module multi_byte_decoder
    import decoder_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OPERAND_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 byte_valid,
    input  logic [DATA_W-1:0]    byte_data,
    output logic                 byte_ready,
    output logic                 uop_valid,
    input  logic                 uop_ready,
    output logic [7:0]           uop_opcode,
    output logic [3:0]           uop_mode,
    output logic [1:0]           uop_len,
    output logic [OPERAND_W-1:0] uop_operand,
    output logic                 uop_illegal
`ifdef MULTI_BYTE_DECODER_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_instr,
    output logic [CNT_W-1:0]     stat_illegal
`endif
);

    if (DATA_W != 8) begin : g_bad_data_w
        $error("multi_byte_decoder: DATA_W must be 8");
    end
    if (OPERAND_W < 2 * DATA_W) begin : g_bad_operand_w
        $error("multi_byte_decoder: OPERAND_W must be at least 2*DATA_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multi_byte_decoder: CNT_W must be positive");
    end

    dec_state_t state, next_state;
    addr_mode_t mode_q, lut_mode;
    logic [1:0] lut_len;
    logic       lut_illegal;
    logic       load_op, load_lo, load_hi;

    opcode_mode_lut u_lut (
        .opcode  (byte_data),
        .mode    (lut_mode),
        .len     (lut_len),
        .illegal (lut_illegal)
    );

    assign uop_valid = (state == S_ISSUE);
    assign uop_mode  = mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_OP;
        else        state <= next_state;
    end

    // In S_ISSUE the next opcode may arrive in the same cycle the uop retires
    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        load_op    = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        if (flush) begin
            next_state = S_OP;
        end else begin
            case (state)
                S_OP: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        load_op    = 1'b1;
                        next_state = (lut_len == 2'd1) ? S_ISSUE : S_LO;
                    end
                end
                S_LO: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        load_lo    = 1'b1;
                        next_state = (uop_len == 2'd2) ? S_ISSUE : S_HI;
                    end
                end
                S_HI: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        load_hi    = 1'b1;
                        next_state = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    byte_ready = uop_ready;
                    if (uop_ready) begin
                        if (byte_valid) begin
                            load_op    = 1'b1;
                            next_state = (lut_len == 2'd1) ? S_ISSUE : S_LO;
                        end else begin
                            next_state = S_OP;
                        end
                    end
                end
                default: next_state = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uop_opcode  <= '0;
            mode_q      <= ERR;
            uop_len     <= 2'd1;
            uop_operand <= '0;
            uop_illegal <= 1'b0;
        end else if (load_op) begin
            uop_opcode  <= byte_data;
            mode_q      <= lut_mode;
            uop_len     <= lut_len;
            uop_operand <= '0;
            uop_illegal <= lut_illegal;
        end else if (load_lo) begin
            uop_operand <= OPERAND_W'(byte_data);
        end else if (load_hi) begin
            uop_operand[2*DATA_W-1:DATA_W] <= byte_data;
        end
    end

`ifdef MULTI_BYTE_DECODER_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_instr   <= '0;
            stat_illegal <= '0;
        end else if (uop_valid && uop_ready) begin
            stat_instr <= sat_inc(stat_instr);
            if (uop_illegal) stat_illegal <= sat_inc(stat_illegal);
        end
    end
`endif

endmodule

// File: tb/tb_multi_byte_decoder.sv
// Self-checking bench for multi_byte_decoder: vector table, directed corner
// sequences and a randomized run against a byte-stream reference model.
module tb_multi_byte_decoder;
    import decoder_pkg::*;

    localparam int DATA_W    = 8;
    localparam int OPERAND_W = 16;
`ifdef MULTI_BYTE_DECODER_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic byte_ready;
    logic uop_valid;
    logic uop_ready = 1'b1;
    logic [7:0] uop_opcode;
    logic [3:0] uop_mode;
    logic [1:0] uop_len;
    logic [OPERAND_W-1:0] uop_operand;
    logic uop_illegal;
`ifdef MULTI_BYTE_DECODER_STATS_EN
    logic [CNT_W-1:0] stat_instr, stat_illegal;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    multi_byte_decoder #(.DATA_W(DATA_W), .OPERAND_W(OPERAND_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_opcode(uop_opcode),
        .uop_mode(uop_mode), .uop_len(uop_len), .uop_operand(uop_operand),
        .uop_illegal(uop_illegal)
`ifdef MULTI_BYTE_DECODER_STATS_EN
        , .stat_instr(stat_instr), .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference classification written per 6502 opcode-map column (low nibble)
    function automatic addr_mode_t ref_mode(input logic [7:0] op);
        addr_mode_t m;
        logic odd;
        odd = op[4];
        m = ERR;
        case (op[3:0])
            4'h1: m = odd ? IND_Y : IND_X;
            4'h5: m = odd ? ZPG_X : ZPG;
            4'h9: m = odd ? ABS_Y : IMM;
            4'hD: m = odd ? ABS_X : ABS;
            4'h8: m = IMPL;
            4'h0: begin
                if (odd) m = REL;
                else if (op == 8'h00 || op == 8'h40 || op == 8'h60) m = IMPL;
                else if (op == 8'h20) m = ABS;
                else if (op == 8'hA0 || op == 8'hC0 || op == 8'hE0) m = IMM;
            end
            4'h2: if (op == 8'hA2) m = IMM;
            4'h4: begin
                if (op == 8'h24 || op == 8'h84 || op == 8'hA4 || op == 8'hC4 || op == 8'hE4) m = ZPG;
                else if (op == 8'h94 || op == 8'hB4) m = ZPG_X;
            end
            4'h6: m = !odd ? ZPG : ((op == 8'h96 || op == 8'hB6) ? ZPG_Y : ZPG_X);
            4'hA: begin
                if (op == 8'h0A || op == 8'h2A || op == 8'h4A || op == 8'h6A) m = ACC;
                else if (op >= 8'h8A && op != 8'hDA && op != 8'hFA) m = IMPL;
            end
            4'hC: begin
                if (op == 8'h6C) m = IND;
                else if (op == 8'hBC) m = ABS_X;
                else if (op == 8'h2C || op == 8'h4C || op == 8'h8C || op == 8'hAC ||
                         op == 8'hCC || op == 8'hEC) m = ABS;
            end
            4'hE: m = !odd ? ABS : (op == 8'hBE ? ABS_Y : (op == 8'h9E ? ERR : ABS_X));
            default: m = ERR;
        endcase
        if (op == 8'h89) m = ERR;
        return m;
    endfunction

    function automatic int ref_len(input addr_mode_t m);
        if (m == IMPL || m == ACC || m == ERR) return 1;
        if (m == ABS || m == ABS_X || m == ABS_Y || m == IND) return 3;
        return 2;
    endfunction

    typedef struct {
        logic [7:0]  op;
        addr_mode_t  mode;
        int          len;
        logic [15:0] operand;
        logic        ill;
    } exp_uop_t;

    logic [7:0] part_q[$];
    exp_uop_t   pend_q[$];
    int         s_instr = 0;
    int         s_ill = 0;
    int         sat_max = (1 << CNT_W) - 1;

    // Scoreboard: accepted bytes are regrouped into instructions and compared on issue
    always @(negedge clk) begin
        exp_uop_t u;
        if (!rst_n) begin
            part_q.delete();
            pend_q.delete();
            s_instr = 0;
            s_ill = 0;
            check("rst_valid", uop_valid, 0);
            check("rst_opcode", uop_opcode, 0);
            check("rst_mode", uop_mode, ERR);
            check("rst_len", uop_len, 1);
            check("rst_operand", uop_operand, 0);
            check("rst_illegal", uop_illegal, 0);
        end else begin
            check("sb_valid", uop_valid, pend_q.size() != 0);
            check("sb_byte_ready", byte_ready, !flush && (pend_q.size() == 0 || uop_ready));
            if (uop_valid && pend_q.size() != 0) begin
                check("sb_opcode", uop_opcode, pend_q[0].op);
                check("sb_mode", uop_mode, pend_q[0].mode);
                check("sb_len", uop_len, pend_q[0].len);
                check("sb_operand", uop_operand, pend_q[0].operand);
                check("sb_illegal", uop_illegal, pend_q[0].ill);
            end
`ifdef MULTI_BYTE_DECODER_STATS_EN
            check("sb_stat_instr", stat_instr, s_instr);
            check("sb_stat_illegal", stat_illegal, s_ill);
`endif
            if (uop_valid && uop_ready && pend_q.size() != 0) begin
                u = pend_q.pop_front();
                if (s_instr < sat_max) s_instr++;
                if (u.ill && s_ill < sat_max) s_ill++;
            end
            if (byte_valid && byte_ready) begin
                part_q.push_back(byte_data);
                if (part_q.size() == ref_len(ref_mode(part_q[0]))) begin
                    u.op      = part_q[0];
                    u.mode    = ref_mode(part_q[0]);
                    u.len     = part_q.size();
                    u.operand = 16'h0000;
                    if (u.len >= 2) u.operand[7:0] = part_q[1];
                    if (u.len == 3) u.operand[15:8] = part_q[2];
                    u.ill     = (u.mode == ERR);
                    pend_q.push_back(u);
                    part_q.delete();
                end
            end
            if (flush) begin
                part_q.delete();
                pend_q.delete();
            end
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk);
            #1;
            t++;
        end
        byte_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h not accepted in 50 cycles", b);
        end
    endtask

    task automatic check_uop(input string name, input logic [7:0] op, input addr_mode_t m,
                             input int len, input logic [15:0] operand, input logic ill);
        @(negedge clk);
        check({name, "_valid"}, uop_valid, 1);
        check({name, "_opcode"}, uop_opcode, op);
        check({name, "_mode"}, uop_mode, m);
        check({name, "_len"}, uop_len, len);
        check({name, "_operand"}, uop_operand, operand);
        check({name, "_illegal"}, uop_illegal, ill);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op, b1, b2;
        addr_mode_t  mode;
        int          len;
        logic [15:0] operand;
        logic        ill;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'hA1, 8'h10, 8'h00, IND_X, 2, 16'h0010, 1'b0};
        tbl[1]  = '{8'hB1, 8'h20, 8'h00, IND_Y, 2, 16'h0020, 1'b0};
        tbl[2]  = '{8'hB6, 8'h05, 8'h00, ZPG_Y, 2, 16'h0005, 1'b0};
        tbl[3]  = '{8'hBE, 8'h00, 8'h12, ABS_Y, 3, 16'h1200, 1'b0};
        tbl[4]  = '{8'h6C, 8'hFE, 8'hFF, IND,   3, 16'hFFFE, 1'b0};
        tbl[5]  = '{8'h94, 8'h07, 8'h00, ZPG_X, 2, 16'h0007, 1'b0};
        tbl[6]  = '{8'h1E, 8'h34, 8'h12, ABS_X, 3, 16'h1234, 1'b0};
        tbl[7]  = '{8'h89, 8'h00, 8'h00, ERR,   1, 16'h0000, 1'b1};
        tbl[8]  = '{8'h9E, 8'h00, 8'h00, ERR,   1, 16'h0000, 1'b1};
        tbl[9]  = '{8'h24, 8'h44, 8'h00, ZPG,   2, 16'h0044, 1'b0};
        tbl[10] = '{8'hC0, 8'h01, 8'h00, IMM,   2, 16'h0001, 1'b0};
        tbl[11] = '{8'h40, 8'h00, 8'h00, IMPL,  1, 16'h0000, 1'b0};
        tbl[12] = '{8'h2A, 8'h00, 8'h00, ACC,   1, 16'h0000, 1'b0};
        tbl[13] = '{8'h80, 8'h00, 8'h00, ERR,   1, 16'h0000, 1'b1};
        tbl[14] = '{8'hF0, 8'h80, 8'h00, REL,   2, 16'h0080, 1'b0};
        tbl[15] = '{8'h20, 8'h00, 8'hC0, ABS,   3, 16'hC000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Immediate load, uop one cycle after the operand byte
        send_byte(8'hA9);
        send_byte(8'h42);
        check_uop("imm", 8'hA9, IMM, 2, 16'h0042, 1'b0);

        // Absolute then accumulator, back to back with no bubble
        send_byte(8'hAD);
        send_byte(8'h34);
        send_byte(8'h12);
        byte_valid = 1'b1;
        byte_data  = 8'h0A;
        @(negedge clk);
        check("b2b_ready", byte_ready, 1);
        check("b2b_abs_valid", uop_valid, 1);
        check("b2b_abs_mode", uop_mode, ABS);
        check("b2b_abs_len", uop_len, 3);
        check("b2b_abs_operand", uop_operand, 16'h1234);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check_uop("b2b_acc", 8'h0A, ACC, 1, 16'h0000, 1'b0);

        // Stalled execute stage: uop held stable, no bytes accepted
        uop_ready = 1'b0;
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h80);
        byte_valid = 1'b1;
        byte_data  = 8'hEA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", uop_valid, 1);
            check("stall_mode", uop_mode, ABS);
            check("stall_operand", uop_operand, 16'h8000);
            check("stall_byte_ready", byte_ready, 0);
            @(posedge clk);
            #1;
        end
        uop_ready = 1'b1;
        @(negedge clk);
        check("release_byte_ready", byte_ready, 1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check_uop("release_impl", 8'hEA, IMPL, 1, 16'h0000, 1'b0);

        // Flush drops a partial instruction and consumes no byte
        send_byte(8'hAD);
        send_byte(8'h34);
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        @(negedge clk);
        check("flush_byte_ready", byte_ready, 0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_uop", uop_valid, 0);
        end
        @(posedge clk);
        #1;
        send_byte(8'h02);
        check_uop("illegal_02", 8'h02, ERR, 1, 16'h0000, 1'b1);

        // Reset in the middle of an absolute instruction
        send_byte(8'hAD);
        send_byte(8'h34);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", uop_valid, 0);
        check("midrst_opcode", uop_opcode, 0);
        check("midrst_mode", uop_mode, ERR);
        check("midrst_len", uop_len, 1);
        check("midrst_operand", uop_operand, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'hD0);
        send_byte(8'hFE);
        check_uop("rel", 8'hD0, REL, 2, 16'h00FE, 1'b0);

        // Vector table
        foreach (tbl[i]) begin
            send_byte(tbl[i].op);
            if (tbl[i].len >= 2) send_byte(tbl[i].b1);
            if (tbl[i].len == 3) send_byte(tbl[i].b2);
            check_uop($sformatf("tbl%0d", i), tbl[i].op, tbl[i].mode, tbl[i].len,
                      tbl[i].operand, tbl[i].ill);
        end

`ifdef MULTI_BYTE_DECODER_STATS_EN
        // Counters saturate at 3 with a 2-bit width
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'hEA);
        send_byte(8'h02);
        send_byte(8'h0A);
        send_byte(8'h03);
        send_byte(8'hA9);
        send_byte(8'h42);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("stat_instr_sat", stat_instr, 3);
        check("stat_illegal", stat_illegal, 2);
        @(posedge clk);
        #1;
`endif

        // Randomized traffic with stalls, flushes and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_data  = 8'($urandom_range(0, 255));
            uop_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        flush      = 1'b0;
        uop_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
